ex_sp_rr_sequencer: RTL and testbench

- Self-timed micro-step sequencer for EX (SP),rr, where rr is HL, IX or IY.
- Owns its own XPT step counter instead of decoding an external one.
- Generates per-step control strobes to the register file, address unit and memory-cycle controller.
- Generalises the fixed EX (SP),HL decode:
  - memory-cycle length and internal-gap length are parameters;
  - the register pair is selectable;
  - WAIT stalls are supported.
- Sits beside the opcode decoders. Started by the decode stage on recognising E3 / DD E3 / FD E3.

---
 rtl/ex_sp_pkg.sv | 39 +++
 rtl/ex_sp_phase_counter.sv | 80 ++++++++
 rtl/ex_sp_rr_sequencer.sv | 120 ++++++++++++
 tb/tb_ex_sp_rr_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_sp_pkg.sv
// Shared types and length helpers for the EX (SP),rr micro-step sequencer.
// Phase order and per-phase lengths live here so the counter and the width check agree.
package ex_sp_pkg;

   typedef enum logic [3:0] {
      PH_IDLE,
      PH_LATCH,
      PH_RD_LO,
      PH_RD_HI,
      PH_GAP1,
      PH_WR_LO,
      PH_WR_HI,
      PH_GAP2,
      PH_END
   } phase_t;

   localparam logic [1:0] PAIR_HL  = 2'b00;
   localparam logic [1:0] PAIR_IX  = 2'b01;
   localparam logic [1:0] PAIR_IY  = 2'b10;
   localparam logic [1:0] PAIR_RSV = 2'b11;

   function automatic int phase_len(input phase_t ph, input int mem_t, input int idle_t);
      case (ph)
         PH_LATCH, PH_END:                       return 1;
         PH_RD_LO, PH_RD_HI, PH_WR_LO, PH_WR_HI: return mem_t;
         PH_GAP1, PH_GAP2:                       return idle_t;
         default:                                return 0;
      endcase
   endfunction

   function automatic int total_steps(input int mem_t, input int idle_t);
      return 2 + 4 * mem_t + 2 * idle_t;
   endfunction

   function automatic logic is_mem(input phase_t ph);
      return (ph == PH_RD_LO) || (ph == PH_RD_HI) || (ph == PH_WR_LO) || (ph == PH_WR_HI);
   endfunction

endpackage

// File: rtl/ex_sp_phase_counter.sv
// Phase register plus T-state down-counter for the EX (SP),rr sequencer.
// Holds on a memory wait at T-index 1 and skips zero-length gap phases.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   PH_IDLE  | waiting for an accepted start
//   PH_LATCH | one step: capture the selected pair
//   PH_RD_LO | MEM_T steps: read low byte from (SP)
//   PH_RD_HI | MEM_T steps: read high byte from (SP+1)
//   PH_GAP1  | IDLE_T internal steps (skipped when IDLE_T == 0)
//   PH_WR_LO | MEM_T steps: write low byte to (SP)
//   PH_WR_HI | MEM_T steps: write high byte to (SP+1)
//   PH_GAP2  | IDLE_T internal steps (skipped when IDLE_T == 0)
//   PH_END   | one step: done pulse, back to idle
module ex_sp_phase_counter
   import ex_sp_pkg::*;
#(
   parameter int MEM_T  = 3,
   parameter int IDLE_T = 1,
   parameter int TIW    = $clog2(MEM_T)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           pair_rsv,
   input  logic           wait_req,
   output phase_t         phase,
   output logic [TIW-1:0] t_idx,
   output logic           stall
);

   localparam int MAXLEN = (MEM_T > IDLE_T) ? MEM_T : IDLE_T;
   localparam int CW     = $clog2(MAXLEN + 1);

   logic [CW-1:0] t_left;
   logic [CW-1:0] load_val;
   logic          t_last;
   phase_t        nxt;

   always_comb begin
      nxt = PH_IDLE;
      case (phase)
         PH_IDLE:  nxt = PH_LATCH;
         PH_LATCH: nxt = pair_rsv ? PH_END : PH_RD_LO;
         PH_RD_LO: nxt = PH_RD_HI;
         PH_RD_HI: nxt = (IDLE_T > 0) ? PH_GAP1 : PH_WR_LO;
         PH_GAP1:  nxt = PH_WR_LO;
         PH_WR_LO: nxt = PH_WR_HI;
         PH_WR_HI: nxt = (IDLE_T > 0) ? PH_GAP2 : PH_END;
         PH_GAP2:  nxt = PH_END;
         default:  nxt = PH_IDLE;
      endcase
   end

   assign load_val = (nxt == PH_IDLE) ? '0 : CW'(phase_len(nxt, MEM_T, IDLE_T) - 1);
   assign t_last   = (t_left == '0);
   // t_left never exceeds MEM_T-1 in a memory phase, so the low bits give the index.
   assign t_idx    = TIW'(MEM_T - 1) - t_left[TIW-1:0];
   assign stall    = is_mem(phase) && (t_left == CW'(MEM_T - 2)) && wait_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase  <= PH_IDLE;
         t_left <= '0;
      end else if (phase == PH_IDLE) begin
         if (start) begin
            phase  <= PH_LATCH;
            t_left <= '0;
         end
      end else if (!stall) begin
         if (!t_last) begin
            t_left <= t_left - 1'b1;
         end else begin
            phase  <= nxt;
            t_left <= load_val;
         end
      end
   end

endmodule

// File: rtl/ex_sp_rr_sequencer.sv
// Self-timed EX (SP),rr sequencer: owns the XPT step count and decodes per-step strobes
// from the registered phase and T-index.
module ex_sp_rr_sequencer
   import ex_sp_pkg::*;
#(
   parameter int XPT_WIDTH = 5,
   parameter int START_XPT = 3,
   parameter int MEM_T     = 3,
   parameter int IDLE_T    = 1
) (
   input  logic                 CLK,
   input  logic                 notRESET,
   input  logic                 Start,
   input  logic [1:0]           PairSel,
   input  logic                 Wait,
   output logic                 Busy,
   output logic [XPT_WIDTH-1:0] XPT,
   output logic [1:0]           PR_PairSel,
   output logic                 PA_SelectPair_low,
   output logic                 PR_Write_Dt,
   output logic                 PR_Write_Dtex,
   output logic [MEM_T-1:0]     PC_R,
   output logic [MEM_T-1:0]     PC_W,
   output logic                 PI_SelectAd_SP,
   output logic                 PI_SelectAdt1,
   output logic                 PI_SelectDt_Dt,
   output logic                 PI_SelectDt_Dtex,
   output logic                 PR_Write_Low,
   output logic                 PR_Write_High,
   output logic                 PR_InvertIn,
   output logic                 P2_Set_CM1,
   output logic                 Pa_Ophd,
   output logic                 Done,
   output logic                 Error
);

   localparam int TIW   = $clog2(MEM_T);
   localparam int TOTAL = total_steps(MEM_T, IDLE_T);

   if (MEM_T < 2) begin : g_bad_mem_t
      $error("ex_sp_rr_sequencer: MEM_T must be at least 2");
   end
   if (IDLE_T < 0) begin : g_bad_idle_t
      $error("ex_sp_rr_sequencer: IDLE_T must not be negative");
   end
   if (START_XPT + TOTAL - 1 >= 2 ** XPT_WIDTH) begin : g_bad_xpt_width
      $error("ex_sp_rr_sequencer: last XPT value does not fit in XPT_WIDTH");
   end

   phase_t           phase;
   logic [TIW-1:0]   t_idx;
   logic             stall;
   logic             start_acc;
   logic             pair_rsv;
   logic             rd;
   logic             wr;
   logic             wr_ok;
   logic [MEM_T-1:0] t_hot;

   assign Busy      = (phase != PH_IDLE);
   assign start_acc = Start && !Busy;
   assign pair_rsv  = (PR_PairSel == PAIR_RSV);

   ex_sp_phase_counter #(
      .MEM_T  (MEM_T),
      .IDLE_T (IDLE_T),
      .TIW    (TIW)
   ) u_phase_counter (
      .clk      (CLK),
      .rst_n    (notRESET),
      .start    (start_acc),
      .pair_rsv (pair_rsv),
      .wait_req (Wait),
      .phase    (phase),
      .t_idx    (t_idx),
      .stall    (stall)
   );

   always_ff @(posedge CLK or negedge notRESET) begin
      if (!notRESET) begin
         PR_PairSel <= PAIR_HL;
         XPT        <= '0;
      end else if (!Busy) begin
         if (Start) begin
            PR_PairSel <= PairSel;
            XPT        <= XPT_WIDTH'(START_XPT);
         end
      end else if (phase == PH_END) begin
         XPT <= '0;
      end else if (!stall) begin
         XPT <= XPT + 1'b1;
      end
   end

   // With MEM_T == 2 the wait T-state is also the last one; block repeated register writes there.
   assign wr_ok = (MEM_T > 2) || !stall;
   assign rd    = (phase == PH_RD_LO) || (phase == PH_RD_HI);
   assign wr    = (phase == PH_WR_LO) || (phase == PH_WR_HI);
   assign t_hot = MEM_T'(1) << t_idx;

   always_comb begin
      PA_SelectPair_low = (phase == PH_LATCH);
      PR_Write_Dt       = (phase == PH_LATCH) && !pair_rsv;
      PR_Write_Dtex     = (phase == PH_LATCH) && !pair_rsv;
      PC_R              = rd ? t_hot : '0;
      PC_W              = wr ? t_hot : '0;
      PI_SelectAd_SP    = rd || wr;
      PI_SelectAdt1     = (phase == PH_RD_HI) || (phase == PH_WR_HI);
      PI_SelectDt_Dt    = (phase == PH_WR_LO);
      PI_SelectDt_Dtex  = (phase == PH_WR_HI);
      PR_Write_Low      = (phase == PH_RD_LO) && t_hot[MEM_T-1] && wr_ok;
      PR_Write_High     = (phase == PH_RD_HI) && t_hot[MEM_T-1] && wr_ok;
      PR_InvertIn       = PR_Write_High;
      P2_Set_CM1        = (phase == PH_END);
      Pa_Ophd           = (phase == PH_END);
      Done              = (phase == PH_END);
      Error             = (phase == PH_END) && pair_rsv;
   end

endmodule

// File: tb/tb_ex_sp_rr_sequencer.sv
// Directed bench for ex_sp_rr_sequencer: default configuration plus a MEM_T=4 / IDLE_T=0 instance.
module tb_ex_sp_rr_sequencer;

   logic       CLK = 1'b0;
   logic       notRESET;
   logic       Start, Wait;
   logic [1:0] PairSel;

   logic       Busy, PA_SelectPair_low, PR_Write_Dt, PR_Write_Dtex;
   logic [4:0] XPT;
   logic [1:0] PR_PairSel;
   logic [2:0] PC_R, PC_W;
   logic       PI_SelectAd_SP, PI_SelectAdt1, PI_SelectDt_Dt, PI_SelectDt_Dtex;
   logic       PR_Write_Low, PR_Write_High, PR_InvertIn, P2_Set_CM1, Pa_Ophd, Done, Error;

   logic       Start_b, Wait_b;
   logic [1:0] PairSel_b;
   logic       Busy_b, PA_SelectPair_low_b, PR_Write_Dt_b, PR_Write_Dtex_b;
   logic [4:0] XPT_b;
   logic [1:0] PR_PairSel_b;
   logic [3:0] PC_R_b, PC_W_b;
   logic       PI_SelectAd_SP_b, PI_SelectAdt1_b, PI_SelectDt_Dt_b, PI_SelectDt_Dtex_b;
   logic       PR_Write_Low_b, PR_Write_High_b, PR_InvertIn_b, P2_Set_CM1_b, Pa_Ophd_b, Done_b, Error_b;

   int n_chk = 0;
   int n_err = 0;
   int wlo, whi;
   int exp_x;

   always #5 CLK = ~CLK;

   ex_sp_rr_sequencer dut (
      .CLK(CLK), .notRESET(notRESET), .Start(Start), .PairSel(PairSel), .Wait(Wait),
      .Busy(Busy), .XPT(XPT), .PR_PairSel(PR_PairSel), .PA_SelectPair_low(PA_SelectPair_low),
      .PR_Write_Dt(PR_Write_Dt), .PR_Write_Dtex(PR_Write_Dtex), .PC_R(PC_R), .PC_W(PC_W),
      .PI_SelectAd_SP(PI_SelectAd_SP), .PI_SelectAdt1(PI_SelectAdt1),
      .PI_SelectDt_Dt(PI_SelectDt_Dt), .PI_SelectDt_Dtex(PI_SelectDt_Dtex),
      .PR_Write_Low(PR_Write_Low), .PR_Write_High(PR_Write_High), .PR_InvertIn(PR_InvertIn),
      .P2_Set_CM1(P2_Set_CM1), .Pa_Ophd(Pa_Ophd), .Done(Done), .Error(Error)
   );

   ex_sp_rr_sequencer #(.XPT_WIDTH(5), .START_XPT(0), .MEM_T(4), .IDLE_T(0)) dut_b (
      .CLK(CLK), .notRESET(notRESET), .Start(Start_b), .PairSel(PairSel_b), .Wait(Wait_b),
      .Busy(Busy_b), .XPT(XPT_b), .PR_PairSel(PR_PairSel_b), .PA_SelectPair_low(PA_SelectPair_low_b),
      .PR_Write_Dt(PR_Write_Dt_b), .PR_Write_Dtex(PR_Write_Dtex_b), .PC_R(PC_R_b), .PC_W(PC_W_b),
      .PI_SelectAd_SP(PI_SelectAd_SP_b), .PI_SelectAdt1(PI_SelectAdt1_b),
      .PI_SelectDt_Dt(PI_SelectDt_Dt_b), .PI_SelectDt_Dtex(PI_SelectDt_Dtex_b),
      .PR_Write_Low(PR_Write_Low_b), .PR_Write_High(PR_Write_High_b), .PR_InvertIn(PR_InvertIn_b),
      .P2_Set_CM1(P2_Set_CM1_b), .Pa_Ophd(Pa_Ophd_b), .Done(Done_b), .Error(Error_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      notRESET = 1'b0; Start = 1'b0; Wait = 1'b0; PairSel = 2'b00;
      Start_b = 1'b0; Wait_b = 1'b0; PairSel_b = 2'b00;
      tick; tick;
      notRESET = 1'b1;
      chk("rst_busy", Busy, 0);
      chk("rst_xpt", XPT, 0);
      chk("rst_pc_r", PC_R, 0);
      chk("rst_done", Done, 0);
      chk("rst_b_busy", Busy_b, 0);
      tick;

      // Baseline HL run; Start re-pulsed at XPT 10 and at END must be ignored.
      Start = 1'b1; PairSel = 2'b00;
      tick;
      Start = 1'b0;
      for (int x = 3; x <= 18; x++) begin
         chk("b_xpt", XPT, x);
         chk("b_busy", Busy, 1);
         chk("b_latch", PA_SelectPair_low, x == 3);
         chk("b_wr_dt", PR_Write_Dt, x == 3);
         chk("b_wr_dtex", PR_Write_Dtex, x == 3);
         chk("b_pc_r", PC_R, (x >= 4 && x <= 9) ? (1 << ((x - 4) % 3)) : 0);
         chk("b_pc_w", PC_W, (x >= 11 && x <= 16) ? (1 << ((x - 11) % 3)) : 0);
         chk("b_ad_sp", PI_SelectAd_SP, (x >= 4 && x <= 9) || (x >= 11 && x <= 16));
         chk("b_adt1", PI_SelectAdt1, (x >= 7 && x <= 9) || (x >= 14 && x <= 16));
         chk("b_dt_dt", PI_SelectDt_Dt, x >= 11 && x <= 13);
         chk("b_dt_dtex", PI_SelectDt_Dtex, x >= 14 && x <= 16);
         chk("b_wr_low", PR_Write_Low, x == 6);
         chk("b_wr_high", PR_Write_High, x == 9);
         chk("b_inv", PR_InvertIn, x == 9);
         chk("b_done", Done, x == 18);
         chk("b_cm1", P2_Set_CM1, x == 18);
         chk("b_ophd", Pa_Ophd, x == 18);
         chk("b_error", Error, 0);
         Start = (x == 10 || x == 18);
         tick;
      end
      Start = 1'b0;
      chk("b_idle_busy", Busy, 0);
      chk("b_idle_xpt", XPT, 0);
      chk("b_idle_done", Done, 0);
      chk("b_idle_pc_r", PC_R, 0);

      // Start one cycle after Busy fell, with a two-cycle wait at XPT 5.
      Start = 1'b1;
      tick;
      Start = 1'b0;
      wlo = 0; whi = 0;
      for (int cyc = 0; cyc <= 17; cyc++) begin
         exp_x = (cyc <= 2) ? 3 + cyc : (cyc <= 4) ? 5 : cyc + 1;
         chk("w_xpt", XPT, exp_x);
         if (exp_x == 5) chk("w_pc_r", PC_R, 3'b010);
         chk("w_done", Done, cyc == 17);
         wlo += int'(PR_Write_Low);
         whi += int'(PR_Write_High);
         if (cyc == 2) Wait = 1'b1;
         if (cyc == 4) Wait = 1'b0;
         tick;
      end
      chk("w_busy_end", Busy, 0);
      chk("w_wr_low_cnt", wlo, 1);
      chk("w_wr_high_cnt", whi, 1);

      // Reserved pair code: LATCH then END with Error.
      PairSel = 2'b11; Start = 1'b1;
      tick;
      Start = 1'b0;
      chk("r_xpt3", XPT, 3);
      chk("r_latch", PA_SelectPair_low, 1);
      chk("r_wr_dt", PR_Write_Dt, 0);
      chk("r_wr_dtex", PR_Write_Dtex, 0);
      chk("r_pc_r3", PC_R, 0);
      tick;
      chk("r_xpt4", XPT, 4);
      chk("r_done", Done, 1);
      chk("r_error", Error, 1);
      chk("r_pc_r4", PC_R, 0);
      chk("r_pc_w4", PC_W, 0);
      tick;
      chk("r_busy_end", Busy, 0);
      chk("r_error_end", Error, 0);

      // Asynchronous reset in the middle of the low-byte write.
      PairSel = 2'b01; Start = 1'b1;
      tick;
      Start = 1'b0;
      repeat (9) tick;
      chk("x_xpt12", XPT, 12);
      chk("x_pc_w12", PC_W, 3'b010);
      chk("x_pair12", PR_PairSel, 2'b01);
      #2 notRESET = 1'b0;
      #1;
      chk("x_busy", Busy, 0);
      chk("x_xpt", XPT, 0);
      chk("x_pc_w", PC_W, 0);
      chk("x_pair", PR_PairSel, 0);
      chk("x_ad_sp", PI_SelectAd_SP, 0);
      chk("x_dt_dt", PI_SelectDt_Dt, 0);
      tick; tick;
      notRESET = 1'b1;
      tick;
      Start = 1'b1;
      tick;
      Start = 1'b0;
      chk("x_restart_xpt", XPT, 3);
      chk("x_restart_pair", PR_PairSel, 2'b01);
      for (int i = 0; i < 40 && Busy; i++) tick;
      chk("x_finish_busy", Busy, 0);

      // Second configuration: MEM_T=4, IDLE_T=0, START_XPT=0, pair IY.
      PairSel_b = 2'b10; Start_b = 1'b1;
      tick;
      Start_b = 1'b0;
      PairSel_b = 2'b00;
      for (int x = 0; x <= 17; x++) begin
         chk("m_xpt", XPT_b, x);
         chk("m_pair", PR_PairSel_b, 2'b10);
         chk("m_pc_r", PC_R_b, (x >= 1 && x <= 8) ? (1 << ((x - 1) % 4)) : 0);
         chk("m_pc_w", PC_W_b, (x >= 9 && x <= 16) ? (1 << ((x - 9) % 4)) : 0);
         chk("m_wr_low", PR_Write_Low_b, x == 4);
         chk("m_wr_high", PR_Write_High_b, x == 8);
         chk("m_done", Done_b, x == 17);
         tick;
      end
      chk("m_busy_end", Busy_b, 0);
      chk("m_xpt_end", XPT_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
